// File: rtl/spi_flash_mmio.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_flash_mmio
// Purpose  : CPU-bus read responder backed by an external SPI NOR flash.
//            Each in-window word read becomes a serial READ (0x03) with a
//            24-bit address and 32 data bits. The result is signalled with a
//            one-cycle memReady pulse. A release-from-power-down (0xAB)
//            command and a settle wait run once after every reset.
// Ports    : clk, reset (sync, active low)
//            memAddress/memWriteData/memWrite/memRead/byteMask : CPU bus in
//            memReadData/memReady                              : CPU bus out
//            busy                                              : not IDLE
//            spi_cs_n/spi_sck/spi_mosi/spi_miso                : SPI mode 0
// Revision : 1.0  initial release
// ============================================================================
module spi_flash_mmio #(
    parameter logic [31:0] BASE_ADDR    = 32'h0010_0000,
    parameter logic [31:0] WINDOW_BYTES = 32'h0010_0000,
    parameter logic [23:0] FLASH_OFFSET = 24'h10_0000,
    parameter int unsigned CLK_DIV      = 1,
    parameter int unsigned WAKE_CYCLES  = 48
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] memAddress,
    input  logic [31:0] memWriteData,
    input  logic        memWrite,
    input  logic        memRead,
    input  logic [3:0]  byteMask,
    output logic [31:0] memReadData,
    output logic        memReady,
    output logic        busy,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    localparam logic [2:0] c_st_wake_cmd  = 3'd0;
    localparam logic [2:0] c_st_wake_wait = 3'd1;
    localparam logic [2:0] c_st_idle      = 3'd2;
    localparam logic [2:0] c_st_cmd       = 3'd3;
    localparam logic [2:0] c_st_addr      = 3'd4;
    localparam logic [2:0] c_st_data      = 3'd5;
    localparam logic [2:0] c_st_done      = 3'd6;
    localparam logic [2:0] c_st_hold      = 3'd7;

    localparam logic [15:0] c_div_last  = 16'(CLK_DIV - 1);
    localparam logic [15:0] c_wake_last = 16'(WAKE_CYCLES - 1);
    localparam logic [32:0] c_win_end   = {1'b0, BASE_ADDR} + {1'b0, WINDOW_BYTES};

    logic [2:0]  r_state, w_state_nxt;
    logic [15:0] r_div,   w_div_nxt;
    logic        r_high,  w_high_nxt;
    logic [5:0]  r_bit,   w_bit_nxt;
    logic [31:0] r_tx,    w_tx_nxt;
    logic [31:0] r_rx,    w_rx_nxt;
    logic        r_cs_n,  w_cs_n_nxt;
    logic        r_sck,   w_sck_nxt;
    logic        r_mosi,  w_mosi_nxt;
    logic [31:0] r_rdata, w_rdata_nxt;
    logic        r_ready, w_ready_nxt;
    logic [15:0] r_wait,  w_wait_nxt;

    logic        w_hit;
    logic [31:0] w_offset;
    logic [23:0] w_flash_addr;
    logic        w_tail;
    logic        w_shifting;
    logic        w_bit_end;
    logic        w_unused;

    // 33-bit compare so a window ending at 4 GiB does not wrap.
    assign w_hit        = (memAddress >= BASE_ADDR) && ({1'b0, memAddress} < c_win_end);
    assign w_offset     = memAddress - BASE_ADDR;
    assign w_flash_addr = FLASH_OFFSET + {w_offset[23:2], 2'b00};
    assign w_unused     = ^{memWriteData, byteMask, w_offset[31:24], w_offset[1:0]};

    // Tail: all bits of the frame are out and SCK is already low; the next
    // edge raises CS.
    assign w_tail     = ((r_state == c_st_wake_cmd) && (r_bit == 6'd8)) ||
                        ((r_state == c_st_data)     && (r_bit == 6'd32));
    assign w_shifting = ((r_state == c_st_wake_cmd) || (r_state == c_st_cmd) ||
                         (r_state == c_st_addr)     || (r_state == c_st_data)) &&
                        !r_cs_n && !w_tail;

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_high_nxt  = r_high;
        w_bit_nxt   = r_bit;
        w_tx_nxt    = r_tx;
        w_rx_nxt    = r_rx;
        w_cs_n_nxt  = r_cs_n;
        w_sck_nxt   = r_sck;
        w_mosi_nxt  = r_mosi;
        w_rdata_nxt = r_rdata;
        w_ready_nxt = 1'b0;
        w_wait_nxt  = r_wait;
        w_bit_end   = 1'b0;

        // Shared bit engine: low phase then high phase, CLK_DIV cycles each.
        if (w_shifting) begin
            if (r_div == c_div_last) begin
                w_div_nxt = '0;
                if (!r_high) begin
                    w_high_nxt = 1'b1;
                    w_sck_nxt  = 1'b1;
                    if (r_state == c_st_data) begin
                        w_rx_nxt = {r_rx[30:0], spi_miso};
                    end
                end else begin
                    w_high_nxt = 1'b0;
                    w_sck_nxt  = 1'b0;
                    w_bit_end  = 1'b1;
                    w_bit_nxt  = r_bit + 6'd1;
                    w_tx_nxt   = {r_tx[30:0], 1'b0};
                    w_mosi_nxt = r_tx[30];
                end
            end else begin
                w_div_nxt = r_div + 16'd1;
            end
        end

        case (r_state)
            c_st_wake_cmd, c_st_cmd: begin
                if (r_cs_n) begin
                    // Frame setup: CS falls with the first bit on MOSI.
                    w_cs_n_nxt = 1'b0;
                    w_mosi_nxt = r_tx[31];
                    w_div_nxt  = '0;
                    w_high_nxt = 1'b0;
                end else if (w_tail) begin
                    w_cs_n_nxt  = 1'b1;
                    w_mosi_nxt  = 1'b0;
                    w_wait_nxt  = '0;
                    w_state_nxt = c_st_wake_wait;
                end else if (w_bit_end && (r_bit == 6'd7) && (r_state == c_st_cmd)) begin
                    w_state_nxt = c_st_addr;
                end
            end
            c_st_wake_wait: begin
                if (r_wait == c_wake_last) begin
                    w_state_nxt = c_st_idle;
                end else begin
                    w_wait_nxt = r_wait + 16'd1;
                end
            end
            c_st_idle: begin
                if (w_hit && memWrite) begin
                    w_ready_nxt = 1'b1;
                    w_state_nxt = c_st_done;
                end else if (w_hit && memRead) begin
                    w_tx_nxt    = {8'h03, w_flash_addr};
                    w_bit_nxt   = '0;
                    w_state_nxt = c_st_cmd;
                end
            end
            c_st_addr: begin
                if (w_bit_end && (r_bit == 6'd31)) begin
                    w_bit_nxt   = '0;
                    w_mosi_nxt  = 1'b0;
                    w_state_nxt = c_st_data;
                end
            end
            c_st_data: begin
                w_mosi_nxt = 1'b0;
                if (w_tail) begin
                    // First byte on the wire lands in the least significant lane.
                    w_cs_n_nxt  = 1'b1;
                    w_ready_nxt = 1'b1;
                    w_rdata_nxt = {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};
                    w_state_nxt = c_st_done;
                end
            end
            c_st_done: begin
                w_state_nxt = c_st_hold;
            end
            default: begin
                // Hold off refetch until the CPU lets go of this request.
                if (!w_hit || !(memRead || memWrite)) begin
                    w_state_nxt = c_st_idle;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_st_wake_cmd;
            r_div   <= '0;
            r_high  <= 1'b0;
            r_bit   <= '0;
            r_tx    <= {8'hAB, 24'h0};
            r_rx    <= '0;
            r_cs_n  <= 1'b1;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
            r_rdata <= '0;
            r_ready <= 1'b0;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_high  <= w_high_nxt;
            r_bit   <= w_bit_nxt;
            r_tx    <= w_tx_nxt;
            r_rx    <= w_rx_nxt;
            r_cs_n  <= w_cs_n_nxt;
            r_sck   <= w_sck_nxt;
            r_mosi  <= w_mosi_nxt;
            r_rdata <= w_rdata_nxt;
            r_ready <= w_ready_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    assign memReadData = r_rdata;
    assign memReady    = r_ready;
    assign busy        = (r_state != c_st_idle);
    assign spi_cs_n    = r_cs_n;
    assign spi_sck     = r_sck;
    assign spi_mosi    = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_mmio.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_flash_mmio
// Purpose  : Self-checking bench: two responders (CLK_DIV=1 and CLK_DIV=3),
//            each attached to a small SPI flash model.
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_flash_mmio;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic        mem_wr    [2];
    logic        mem_rd    [2];
    logic [3:0]  byte_mask [2];
    logic [31:0] rdata     [2];
    logic        ready     [2];
    logic        busy      [2];
    logic        cs_n      [2];
    logic        sck       [2];
    logic        mosi      [2];
    logic        miso      [2];

    logic [7:0]  flash_bytes [2][4];
    int          cs_falls    [2];
    logic [31:0] last_cmd    [2];
    int          last_nbits  [2];

    int n_checks = 0;
    int n_fail   = 0;

    spi_flash_mmio #(.CLK_DIV(1)) u_dut0 (
        .clk(clk), .reset(rst_n), .memAddress(mem_addr[0]), .memWriteData(mem_wdata[0]),
        .memWrite(mem_wr[0]), .memRead(mem_rd[0]), .byteMask(byte_mask[0]),
        .memReadData(rdata[0]), .memReady(ready[0]), .busy(busy[0]),
        .spi_cs_n(cs_n[0]), .spi_sck(sck[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0])
    );

    spi_flash_mmio #(.CLK_DIV(3)) u_dut1 (
        .clk(clk), .reset(rst_n), .memAddress(mem_addr[1]), .memWriteData(mem_wdata[1]),
        .memWrite(mem_wr[1]), .memRead(mem_rd[1]), .byteMask(byte_mask[1]),
        .memReadData(rdata[1]), .memReady(ready[1]), .busy(busy[1]),
        .spi_cs_n(cs_n[1]), .spi_sck(sck[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1])
    );

    // Flash model: captures the first 32 MOSI bits (command + address) and
    // returns flash_bytes[0..3] MSB-first, shifting on SCK falling edges.
    for (genvar g = 0; g < 2; g++) begin : g_flash
        int          nbits = 0;
        logic [31:0] sh    = '0;
        always @(negedge cs_n[g] or posedge sck[g]) begin
            if (sck[g]) begin
                if (!cs_n[g]) begin
                    if (nbits < 32) sh = {sh[30:0], mosi[g]};
                    nbits = nbits + 1;
                end
            end else begin
                nbits = 0;
                sh = '0;
                cs_falls[g] = cs_falls[g] + 1;
            end
        end
        always @(negedge sck[g]) begin
            if (!cs_n[g] && nbits >= 32 && nbits < 64)
                miso[g] = flash_bytes[g][(nbits - 32) / 8][7 - ((nbits - 32) % 8)];
        end
        always @(posedge cs_n[g]) begin
            last_cmd[g]   = sh;
            last_nbits[g] = nbits;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_bytes(input int idx, input logic [31:0] wb);
        flash_bytes[idx][0] = wb[31:24];
        flash_bytes[idx][1] = wb[23:16];
        flash_bytes[idx][2] = wb[15:8];
        flash_bytes[idx][3] = wb[7:0];
    endtask

    // Waits (bounded) until cs_n equals lvl; counts SCK-high samples on the way.
    task automatic wait_cs(input int idx, input logic lvl, input int bound,
                           output int ok, output int hi);
        ok = 0;
        hi = 0;
        for (int k = 0; k < bound; k++) begin
            @(posedge clk); #1;
            if (sck[idx]) hi++;
            if (cs_n[idx] === lvl) begin
                ok = 1;
                break;
            end
        end
    endtask

    // Drives a request at a falling edge; edge index 0 is the accepting edge.
    task automatic run_req(input int idx, input logic [31:0] addr, input logic rd,
                           input logic wr, input logic [31:0] wb, input int limit,
                           output int lat, output int hi, output int falls,
                           output logic [31:0] d_rdy);
        int f0;
        @(negedge clk);
        load_bytes(idx, wb);
        f0 = cs_falls[idx];
        mem_addr[idx] = addr;
        mem_rd[idx]   = rd;
        mem_wr[idx]   = wr;
        lat   = -1;
        hi    = 0;
        d_rdy = '0;
        for (int k = 0; k < limit; k++) begin
            @(posedge clk); #1;
            if (sck[idx]) hi++;
            if (ready[idx]) begin
                lat   = k;
                d_rdy = rdata[idx];
                break;
            end
        end
        @(negedge clk);
        mem_rd[idx] = 1'b0;
        mem_wr[idx] = 1'b0;
        repeat (4) @(negedge clk);
        falls = cs_falls[idx] - f0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [31:0] wire_bytes;
        int          exp_lat;
        int          exp_falls;
        int          exp_hi;
        logic [31:0] exp_data;
        logic [31:0] exp_cmd;
    } vec_t;

    vec_t        vecs [11];
    int          lat, hi, falls, ok, cnt, f0;
    logic [31:0] d_rdy;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          addr          rd    wr    wire bytes     lat  falls hi  data           cmd
        vecs[0]  = '{32'h0010_0004, 1'b1, 1'b0, 32'h1122_3344, 130, 1, 64, 32'h4433_2211, 32'h0310_0004};
        vecs[1]  = '{32'h0010_0008, 1'b1, 1'b0, 32'hA55A_0FF0, 130, 1, 64, 32'hF00F_5AA5, 32'h0310_0008};
        vecs[2]  = '{32'h001F_FFFC, 1'b1, 1'b0, 32'h0180_FF00, 130, 1, 64, 32'h00FF_8001, 32'h031F_FFFC};
        vecs[3]  = '{32'h0010_0003, 1'b1, 1'b0, 32'hDEAD_BEEF, 130, 1, 64, 32'hEFBE_ADDE, 32'h0310_0000};
        vecs[4]  = '{32'h0000_0100, 1'b1, 1'b0, 32'h0, -1, 0, 0, 32'hEFBE_ADDE, 32'h0};
        vecs[5]  = '{32'h0020_0000, 1'b1, 1'b0, 32'h0, -1, 0, 0, 32'hEFBE_ADDE, 32'h0};
        vecs[6]  = '{32'h000F_FFFC, 1'b1, 1'b0, 32'h0, -1, 0, 0, 32'hEFBE_ADDE, 32'h0};
        vecs[7]  = '{32'h0010_0000, 1'b0, 1'b1, 32'h0, 0, 0, 0, 32'hEFBE_ADDE, 32'h0};
        vecs[8]  = '{32'h0010_0010, 1'b1, 1'b1, 32'h0, 0, 0, 0, 32'hEFBE_ADDE, 32'h0};
        vecs[9]  = '{32'h0030_0000, 1'b0, 1'b1, 32'h0, -1, 0, 0, 32'hEFBE_ADDE, 32'h0};
        vecs[10] = '{32'h0010_0000, 1'b1, 1'b0, 32'h0000_0080, 130, 1, 64, 32'h8000_0000, 32'h0310_0000};

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_addr[i]  = '0;
            mem_wdata[i] = 32'hCAFE_F00D;
            mem_wr[i]    = 1'b0;
            mem_rd[i]    = 1'b0;
            byte_mask[i] = 4'hF;
            cs_falls[i]  = 0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n",  64'(cs_n[0]),  64'h1);
        check("rst_sck",   64'(sck[0]),   64'h0);
        check("rst_mosi",  64'(mosi[0]),  64'h0);
        check("rst_rdata", 64'(rdata[0]), 64'h0);
        check("rst_ready", 64'(ready[0]), 64'h0);
        check("rst_busy",  64'(busy[0]),  64'h1);

        // Wake sequence
        @(negedge clk);
        rst_n = 1'b1;
        wait_cs(0, 1'b0, 10, ok, hi);
        check("wake_cs_fall", 64'(ok), 64'h1);
        wait_cs(0, 1'b1, 100, ok, hi);
        check("wake_cs_rise", 64'(ok), 64'h1);
        check("wake_sck_periods", 64'(hi), 64'd8);
        check("wake_nbits", 64'(last_nbits[0]), 64'd8);
        check("wake_byte", 64'(last_cmd[0]), 64'h0000_00AB);
        cnt = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            cnt++;
            if (!busy[0]) break;
        end
        check("wake_wait_cycles", 64'(cnt), 64'd48);
        for (int k = 0; k < 400 && busy[1]; k++) @(posedge clk);

        // Table-driven requests on the CLK_DIV=1 instance
        for (int i = 0; i < 11; i++) begin
            run_req(0, vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wire_bytes, 
                    (vecs[i].exp_lat < 0) ? 200 : 1000, lat, hi, falls, d_rdy);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("v%0d_cs_falls", i), 64'(falls), 64'(vecs[i].exp_falls));
            check($sformatf("v%0d_sck_high", i), 64'(hi), 64'(vecs[i].exp_hi));
            check($sformatf("v%0d_rdata_after", i), 64'(rdata[0]), 64'(vecs[i].exp_data));
            if (vecs[i].exp_lat >= 0)
                check($sformatf("v%0d_rdata_ready", i), 64'(d_rdy), 64'(vecs[i].exp_data));
            if (vecs[i].exp_falls == 1) begin
                check($sformatf("v%0d_cmd_addr", i), 64'(last_cmd[0]), 64'(vecs[i].exp_cmd));
                check($sformatf("v%0d_nbits", i), 64'(last_nbits[0]), 64'd64);
            end
        end

        // Hold: request kept high after memReady must not refetch
        @(negedge clk);
        load_bytes(0, 32'h1122_3344);
        f0 = cs_falls[0];
        mem_addr[0] = 32'h0010_0004;
        mem_rd[0]   = 1'b1;
        lat = -1;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            if (ready[0]) begin
                lat = k;
                break;
            end
        end
        check("hold_latency", 64'(lat), 64'd130);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (ready[0]) cnt++;
        end
        check("hold_no_ready", 64'(cnt), 64'd0);
        check("hold_cs_falls", 64'(cs_falls[0] - f0), 64'd1);
        check("hold_rdata", 64'(rdata[0]), 64'h4433_2211);
        @(negedge clk);
        mem_rd[0] = 1'b0;
        run_req(0, 32'h0010_0008, 1'b1, 1'b0, 32'h99AA_BBCC, 1000, lat, hi, falls, d_rdy);
        check("hold_next_latency", 64'(lat), 64'd130);
        check("hold_next_data", 64'(d_rdy), 64'hCCBB_AA99);
        check("hold_next_cmd", 64'(last_cmd[0]), 64'h0310_0008);

        // CLK_DIV=3 instance
        run_req(1, 32'h001F_FFFE, 1'b1, 1'b0, 32'h1234_5678, 1000, lat, hi, falls, d_rdy);
        check("div3_latency", 64'(lat), 64'd386);
        check("div3_sck_high", 64'(hi), 64'd192);
        check("div3_cs_falls", 64'(falls), 64'd1);
        check("div3_data", 64'(d_rdy), 64'h7856_3412);
        check("div3_cmd_addr", 64'(last_cmd[1]), 64'h031F_FFFC);

        // Reset during the address phase
        @(negedge clk);
        load_bytes(0, 32'h1122_3344);
        mem_addr[0] = 32'h0010_0004;
        mem_rd[0]   = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_cs_n",  64'(cs_n[0]),  64'h1);
        check("mid_rst_sck",   64'(sck[0]),   64'h0);
        check("mid_rst_rdata", 64'(rdata[0]), 64'h0);
        check("mid_rst_busy",  64'(busy[0]),  64'h1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cs(0, 1'b0, 10, ok, hi);
        wait_cs(0, 1'b1, 100, ok, hi);
        check("mid_rst_wake_seen", 64'(ok), 64'h1);
        check("mid_rst_wake_byte", 64'(last_cmd[0]), 64'h0000_00AB);
        check("mid_rst_wake_nbits", 64'(last_nbits[0]), 64'd8);
        lat = -1;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            if (ready[0]) begin
                lat = k;
                break;
            end
        end
        check("mid_rst_read_done", 64'(lat >= 0), 64'h1);
        check("mid_rst_read_data", 64'(rdata[0]), 64'h4433_2211);
        check("mid_rst_read_cmd", 64'(last_cmd[0]), 64'h0310_0004);
        @(negedge clk);
        mem_rd[0] = 1'b0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
